// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel-rate divider, column/line counters, registered
// sync/active-video decodes and line/frame start strobes.
module vga_timing_generator #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pixelTick,
  output logic [9:0] hCounter,
  output logic [9:0] vCounter,
  output logic       hSync,
  output logic       vSync,
  output logic       vidOn,
  output logic       lineStart,
  output logic       frameStart
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Refuse to elaborate timings that do not fit the 10-bit counters
  if (H_TOTAL > 1024 || H_TOTAL == 0) begin : g_bad_h_total
    $error("vga_timing_generator: H_TOTAL must be 1..1024");
  end
  if (V_TOTAL > 1024 || V_TOTAL == 0) begin : g_bad_v_total
    $error("vga_timing_generator: V_TOTAL must be 1..1024");
  end
  if (CLK_DIV == 0) begin : g_bad_clk_div
    $error("vga_timing_generator: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_count;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_active;
  logic             vs_active;
  logic             vid_next;

  // Pixel-rate enable; qualified by reset so it is also low in reset when CLK_DIV = 1
  always_comb begin
    pixelTick = enable & reset & (div_count == DIV_LAST);
  end

  // Divider: free-runs while enabled, holds its count while disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_count <= '0;
    end else if (enable) begin
      if (div_count == DIV_LAST) begin
        div_count <= '0;
      end else begin
        div_count <= div_count + 1'b1;
      end
    end
  end

  // Next counter values and the decodes derived from them
  always_comb begin
    h_next = hCounter;
    v_next = vCounter;
    h_wrap = (hCounter == H_LAST);
    v_wrap = (vCounter == V_LAST);
    if (pixelTick) begin
      if (h_wrap) begin
        h_next = '0;
        if (v_wrap) begin
          v_next = '0;
        end else begin
          v_next = vCounter + 10'd1;
        end
      end else begin
        h_next = hCounter + 10'd1;
      end
    end
    hs_active = ({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END);
    vs_active = ({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END);
    vid_next  = ({1'b0, h_next} < H_VIS) && ({1'b0, v_next} < V_VIS);
  end

  // Column and line counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hCounter <= '0;
      vCounter <= '0;
    end else begin
      hCounter <= h_next;
      vCounter <= v_next;
    end
  end

  // Registered decodes from next counter values, so they line up with the counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hSync <= ~SYNC_POL;
      vSync <= ~SYNC_POL;
      vidOn <= 1'b0;
    end else if (enable) begin
      hSync <= hs_active ? SYNC_POL : ~SYNC_POL;
      vSync <= vs_active ? SYNC_POL : ~SYNC_POL;
      vidOn <= vid_next;
    end
  end

  // Line/frame strobes mark the first cycle showing a wrapped counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      lineStart  <= pixelTick & h_wrap;
      frameStart <= pixelTick & h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator: default timing, CLK_DIV=1 with
// positive sync, and a tiny raster for frame-level and async-reset checks.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, tick_a, hs_a, vs_a, vid_a, ls_a, fs_a;
  logic [9:0] h_a, v_a;
  logic       rst_b, en_b, tick_b, hs_b, vs_b, vid_b, ls_b, fs_b;
  logic [9:0] h_b, v_b;
  logic       rst_c, en_c, tick_c, hs_c, vs_c, vid_c, ls_c, fs_c;
  logic [9:0] h_c, v_c;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_generator u_dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .pixelTick(tick_a),
    .hCounter(h_a), .vCounter(v_a), .hSync(hs_a), .vSync(vs_a),
    .vidOn(vid_a), .lineStart(ls_a), .frameStart(fs_a)
  );

  vga_timing_generator #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .pixelTick(tick_b),
    .hCounter(h_b), .vCounter(v_b), .hSync(hs_b), .vSync(vs_b),
    .vidOn(vid_b), .lineStart(ls_b), .frameStart(fs_b)
  );

  // 16 x 10 raster: hsync on h 10..12, vsync on v 7..8, 3 clks per pixel
  vga_timing_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(3), .SYNC_POL(1'b0)
  ) u_dut_c (
    .clk(clk), .reset(rst_c), .enable(en_c), .pixelTick(tick_c),
    .hCounter(h_c), .vCounter(v_c), .hSync(hs_c), .vSync(vs_c),
    .vidOn(vid_c), .lineStart(ls_c), .frameStart(fs_c)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  first_lo, last_lo, lo_cnt, vid_off, ls_cnt, prev_h, prev_v;
  int  steps, no_tick, skips, ticks, nfs, vs_min, vs_max, vs_cnt;
  bit  arrived;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
    repeat (3) @(negedge clk);

    // ---- A: reset state ----
    check_val("a_rst_h", h_a, 0);
    check_val("a_rst_v", v_a, 0);
    check_val("a_rst_tick", tick_a, 0);
    check_val("a_rst_vid", vid_a, 0);
    check_val("a_rst_hs", hs_a, 1);
    check_val("a_rst_vs", vs_a, 1);
    check_val("a_rst_ls", ls_a, 0);
    check_val("a_rst_fs", fs_a, 0);
    rst_a = 1'b1;

    // ---- A: first edges after release ----
    @(negedge clk);
    check_val("a_e1_h", h_a, 0);
    check_val("a_e1_vid", vid_a, 1);
    check_val("a_e1_hs", hs_a, 1);
    check_val("a_e1_vs", vs_a, 1);
    check_val("a_e1_tick", tick_a, 1);
    @(negedge clk);
    check_val("a_e2_h", h_a, 1);
    check_val("a_e2_tick", tick_a, 0);
    @(negedge clk);
    check_val("a_e3_h", h_a, 1);
    check_val("a_e3_tick", tick_a, 1);
    @(negedge clk);
    check_val("a_e4_h", h_a, 2);

    // ---- A: one full line ----
    first_lo = -1; last_lo = -1; lo_cnt = 0; vid_off = -1; ls_cnt = 0;
    prev_h = 2; arrived = 1'b0;
    for (int i = 0; i < 2000 && !arrived; i++) begin
      @(negedge clk);
      if (ls_a) ls_cnt++;
      if (h_a == 10'd0 && v_a == 10'd1) begin
        arrived = 1'b1;
      end else begin
        if (tick_a && !hs_a) begin
          if (first_lo < 0) first_lo = int'(h_a);
          last_lo = int'(h_a);
          lo_cnt++;
        end
        if (!vid_a && vid_off < 0) vid_off = int'(h_a);
        prev_h = int'(h_a);
      end
    end
    check_val("a_line_arrived", arrived, 1);
    check_val("a_line_ls_at_wrap", ls_a, 1);
    check_val("a_line_ls_count", ls_cnt, 1);
    check_val("a_line_last_h", prev_h, 799);
    check_val("a_hs_first", first_lo, 656);
    check_val("a_hs_last", last_lo, 751);
    check_val("a_hs_width", lo_cnt, 96);
    check_val("a_vid_off_h", vid_off, 640);
    check_val("a_line_vs", vs_a, 1);

    // ---- A: enable hold at h = 100 ----
    arrived = 1'b0;
    for (int i = 0; i < 400 && !arrived; i++) begin
      @(negedge clk);
      if (h_a == 10'd100) arrived = 1'b1;
    end
    check_val("a_reach_100", arrived, 1);
    en_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_val("a_hold_h", h_a, 100);
      check_val("a_hold_tick", tick_a, 0);
    end
    en_a = 1'b1;
    @(negedge clk);
    check_val("a_resume_h0", h_a, 100);
    check_val("a_resume_tick", tick_a, 1);
    @(negedge clk);
    check_val("a_resume_h1", h_a, 101);
    check_val("a_resume_v", v_a, 1);

    // ---- B: CLK_DIV = 1, SYNC_POL = 1 ----
    check_val("b_rst_hs", hs_b, 0);
    check_val("b_rst_tick", tick_b, 0);
    rst_b = 1'b1;
    @(negedge clk);
    check_val("b_e1_tick", tick_b, 1);
    check_val("b_e1_h", h_b, 1);
    check_val("b_e1_vid", vid_b, 1);
    check_val("b_e1_hs", hs_b, 0);
    steps = 0; no_tick = 0; skips = 0; first_lo = -1; last_lo = -1; lo_cnt = 0;
    prev_h = 1; arrived = 1'b0;
    for (int i = 0; i < 1000 && !arrived; i++) begin
      @(negedge clk);
      steps++;
      if (!tick_b) no_tick++;
      if (h_b == 10'd0 && v_b == 10'd1) begin
        arrived = 1'b1;
      end else begin
        if (int'(h_b) != prev_h + 1) skips++;
        if (hs_b) begin
          if (first_lo < 0) first_lo = int'(h_b);
          last_lo = int'(h_b);
          lo_cnt++;
        end
        prev_h = int'(h_b);
      end
    end
    check_val("b_arrived", arrived, 1);
    check_val("b_steps", steps, 799);
    check_val("b_no_tick", no_tick, 0);
    check_val("b_skips", skips, 0);
    check_val("b_last_h", prev_h, 799);
    check_val("b_hs_first", first_lo, 656);
    check_val("b_hs_last", last_lo, 751);
    check_val("b_hs_width", lo_cnt, 96);
    check_val("b_ls_at_wrap", ls_b, 1);

    // ---- C: frame structure on the small raster ----
    rst_c = 1'b1;
    @(negedge clk);
    check_val("c_start_h", h_c, 0);
    check_val("c_start_fs", fs_c, 0);
    check_val("c_start_ls", ls_c, 0);
    ticks = 0; ls_cnt = 0; nfs = 0; vs_min = -1; vs_max = -1; vs_cnt = 0;
    prev_h = 0; prev_v = 0;
    for (int i = 0; i < 2000 && nfs < 2; i++) begin
      @(negedge clk);
      if (fs_c) begin
        check_val("c_fs_ls", ls_c, 1);
        check_val("c_fs_h", h_c, 0);
        check_val("c_fs_v", v_c, 0);
        check_val("c_fs_prev_h", prev_h, 15);
        check_val("c_fs_prev_v", prev_v, 9);
        check_val("c_frame_ticks", ticks, 160);
        if (nfs == 1) check_val("c_frame_lines", ls_cnt, 10);
        nfs++;
        ticks = 0;
        ls_cnt = 0;
      end
      if (tick_c) ticks++;
      if (ls_c) ls_cnt++;
      if (tick_c && !vs_c) begin
        if (vs_min < 0) vs_min = int'(v_c);
        vs_max = int'(v_c);
        vs_cnt++;
      end
      prev_h = int'(h_c);
      prev_v = int'(v_c);
    end
    check_val("c_frames_seen", nfs, 2);
    check_val("c_vs_first", vs_min, 7);
    check_val("c_vs_last", vs_max, 8);
    check_val("c_vs_pixels", vs_cnt, 64);

    // ---- C: asynchronous reset inside both sync windows ----
    arrived = 1'b0;
    for (int i = 0; i < 1000 && !arrived; i++) begin
      @(negedge clk);
      if (h_c == 10'd11 && v_c == 10'd7) arrived = 1'b1;
    end
    check_val("c_reach_11_7", arrived, 1);
    check_val("c_pre_hs", hs_c, 0);
    check_val("c_pre_vs", vs_c, 0);
    #2 rst_c = 1'b0;
    #1;
    check_val("c_arst_h", h_c, 0);
    check_val("c_arst_v", v_c, 0);
    check_val("c_arst_hs", hs_c, 1);
    check_val("c_arst_vs", vs_c, 1);
    check_val("c_arst_vid", vid_c, 0);
    check_val("c_arst_tick", tick_c, 0);
    check_val("c_arst_ls", ls_c, 0);
    check_val("c_arst_fs", fs_c, 0);
    @(negedge clk);
    rst_c = 1'b1;
    @(negedge clk);
    check_val("c_restart_h", h_c, 0);
    check_val("c_restart_v", v_c, 0);
    check_val("c_restart_vid", vid_c, 1);
    check_val("c_restart_fs", fs_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
